// File: rtl/ff_pipe_if.sv
// ff_pipe_if: handshake bundle for the ff_pipe elastic register pipeline.
// The slave modport is the pipeline's view. The master modport is the view
// of the logic that feeds words in and drains them out.
interface ff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(2 * DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );
endinterface

// File: rtl/ff_pipe.sv
// ff_pipe: chain of DEPTH valid/ready register stages, WIDTH bits each, with
// back-pressure, synchronous flush and a registered occupancy counter.
//
// Optional feature macro: FF_PIPE_SKID_EN
//   undefined - one register per stage, ready ripples combinationally from
//               out_ready, capacity DEPTH.
//   defined   - each stage has an extra skid register, ready is registered,
//               capacity 2*DEPTH, no combinational input-to-output path.
module ff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     res,
    input  logic     flush,
    ff_pipe_if.slave bus
);
    localparam int CW = $clog2(2 * DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [DEPTH:0]   ready;
    logic [CW-1:0]    count_q;
    logic             in_acc;
    logic             out_acc;

    // Each stage is fed by the stage before it; stage 0 is fed by the input.
    always_comb begin
        up_valid   = '0;
        up_valid[0] = bus.in_valid;
        up_data[0]  = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid[i] = valid[i-1];
            up_data[i]  = data[i-1];
        end
    end

`ifdef FF_PIPE_SKID_EN
    logic [DEPTH-1:0] skid_valid;
    logic [WIDTH-1:0] skid_data [DEPTH];

    // A stage can take a word as long as its skid slot is free.
    always_comb begin
        ready        = '0;
        ready[DEPTH] = bus.out_ready;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = !skid_valid[i];
        end
    end

    // Main register drains skid first; a stalled stage parks the arriving word in skid.
    always_ff @(posedge clk) begin
        if (res) begin
            valid      <= '0;
            skid_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i]      <= '0;
                skid_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!valid[i] || ready[i+1]) begin
                    if (skid_valid[i]) begin
                        valid[i]      <= 1'b1;
                        skid_valid[i] <= 1'b0;
                        if (!flush) data[i] <= skid_data[i];
                    end else if (up_valid[i] && ready[i]) begin
                        valid[i] <= 1'b1;
                        if (!flush) data[i] <= up_data[i];
                    end else begin
                        valid[i] <= 1'b0;
                    end
                end else if (up_valid[i] && ready[i]) begin
                    skid_valid[i] <= 1'b1;
                    if (!flush) skid_data[i] <= up_data[i];
                end
            end
            if (flush) begin
                valid      <= '0;
                skid_valid <= '0;
            end
        end
    end
`else
    // Stage i is ready if it or any stage downstream of it is empty, or the
    // consumer is taking the last word; this is the unrolled ready chain.
    always_comb begin
        ready        = '0;
        ready[DEPTH] = bus.out_ready;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = bus.out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!valid[j]) ready[i] = 1'b1;
            end
        end
    end

    // Load a stage on accept, empty it when its word moves on with nothing behind.
    always_ff @(posedge clk) begin
        if (res) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (up_valid[i] && ready[i]) begin
                    valid[i] <= 1'b1;
                    if (!flush) data[i] <= up_data[i];
                end else if (ready[i+1]) begin
                    valid[i] <= 1'b0;
                end
            end
            if (flush) valid <= '0;
        end
    end
`endif

    assign in_acc  = bus.in_valid && ready[0];
    assign out_acc = valid[DEPTH-1] && bus.out_ready;

    // Occupancy follows accepts at both ends; flush drops everything stored.
    always_ff @(posedge clk) begin
        if (res || flush) begin
            count_q <= '0;
        end else if (in_acc && !out_acc) begin
            count_q <= count_q + CW'(1);
        end else if (out_acc && !in_acc) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign bus.in_ready  = !res && ready[0];
    assign bus.out_valid = !res && valid[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];
    assign bus.count     = count_q;
endmodule
